// File: rtl/mspi_master_m.sv
// Multi-lane SPI master: SCK derived from clk via a runtime divider, all CPOL/CPHA modes,
// single-entry transmit buffer and inter-frame gap. Define MSPI_LOOPBACK_EN to sample MOSI instead of MISO.
module mspi_master_m #(
    parameter int DW    = 32,
    parameter int SPI_W = 4,
    parameter int DIV_W = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_cpol,
    input  logic             cfg_cpha,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [DW-1:0]    tx_data,
    output logic             rx_valid,
    output logic [DW-1:0]    rx_data,
    output logic             busy,
    output logic             SCK,
    output logic             CSn,
    output logic [SPI_W-1:0] MOSI,
    input  logic [SPI_W-1:0] MISO
);

    localparam int SLICES = DW / SPI_W;
    localparam int SCW    = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int GW     = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t             state_reg, state_next;
    logic [DIV_W-1:0]   cnt_reg, cnt_next;
    logic [DIV_W-1:0]   div_reg, div_next;
    logic               cpol_reg, cpol_next;
    logic               cpha_reg, cpha_next;
    logic [DW-1:0]      buf_reg, buf_next;
    logic               buf_full_reg, buf_full_next;
    logic [DW-1:0]      tx_sr_reg, tx_sr_next;
    logic [DW-1:0]      rx_sr_reg, rx_sr_next;
    logic [DW-1:0]      rx_data_reg, rx_data_next;
    logic               rx_valid_reg, rx_valid_next;
    logic [SCW-1:0]     slice_reg, slice_next;
    logic               phase_reg, phase_next;
    logic [GW-1:0]      gap_reg, gap_next;
    logic               sck_reg, sck_next;
    logic               csn_reg, csn_next;
    logic [SPI_W-1:0]   mosi_reg, mosi_next;

    logic               tick;
    logic               accept;
    logic               start;
    logic [SPI_W-1:0]   sample_in;

    genvar gi;
    generate
        for (gi = 0; gi < SPI_W; gi++) begin : g_lane
`ifdef MSPI_LOOPBACK_EN
            assign sample_in[gi] = mosi_reg[gi];
`else
            assign sample_in[gi] = MISO[gi];
`endif
        end
    endgenerate

    assign tick   = (state_reg != S_IDLE) && (cnt_reg == div_reg);
    assign accept = tx_valid && !buf_full_reg;
    assign start  = (state_reg == S_IDLE) && buf_full_reg;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = (state_reg == S_IDLE || tick) ? '0 : cnt_reg + DIV_W'(1);
        div_next      = div_reg;
        cpol_next     = cpol_reg;
        cpha_next     = cpha_reg;
        buf_next      = buf_reg;
        buf_full_next = accept || (buf_full_reg && !start);
        tx_sr_next    = tx_sr_reg;
        rx_sr_next    = rx_sr_reg;
        rx_data_next  = rx_data_reg;
        rx_valid_next = 1'b0;
        slice_next    = slice_reg;
        phase_next    = phase_reg;
        gap_next      = gap_reg;
        sck_next      = sck_reg;
        csn_next      = csn_reg;
        mosi_next     = mosi_reg;

        if (accept) begin
            buf_next = tx_data;
        end

        case (state_reg)
            S_IDLE: begin
                csn_next = 1'b1;
                sck_next = cfg_cpol;
                if (buf_full_reg) begin
                    state_next = S_SETUP;
                    div_next   = cfg_div;
                    cpol_next  = cfg_cpol;
                    cpha_next  = cfg_cpha;
                    csn_next   = 1'b0;
                    slice_next = '0;
                    phase_next = 1'b0;
                    // CPHA=0 must present slice 0 before the first (sampling) leading edge
                    if (!cfg_cpha) begin
                        mosi_next  = buf_reg[DW-1 -: SPI_W];
                        tx_sr_next = buf_reg << SPI_W;
                    end else begin
                        tx_sr_next = buf_reg;
                    end
                end
            end
            S_SETUP: begin
                if (tick) begin
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (tick) begin
                    sck_next   = !sck_reg;
                    phase_next = !phase_reg;
                    if (phase_reg) begin
                        slice_next = slice_reg + SCW'(1);
                    end
                    // phase 0 is a leading edge; CPHA selects which phase samples
                    if (phase_reg == cpha_reg) begin
                        rx_sr_next = (rx_sr_reg << SPI_W) | DW'(sample_in);
                    end else begin
                        mosi_next  = tx_sr_reg[DW-1 -: SPI_W];
                        tx_sr_next = tx_sr_reg << SPI_W;
                    end
                    if (phase_reg && slice_reg == SCW'(SLICES - 1)) begin
                        state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                sck_next = cpol_reg;
                if (tick) begin
                    state_next    = S_GAP;
                    csn_next      = 1'b1;
                    rx_data_next  = rx_sr_reg;
                    rx_valid_next = 1'b1;
                    gap_next      = '0;
                end
            end
            S_GAP: begin
                csn_next = 1'b1;
                if (tick) begin
                    if (gap_reg == GW'(GAP - 1)) begin
                        state_next = S_IDLE;
                    end else begin
                        gap_next = gap_reg + GW'(1);
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                csn_next   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            div_reg      <= '0;
            cpol_reg     <= 1'b0;
            cpha_reg     <= 1'b0;
            buf_reg      <= '0;
            buf_full_reg <= 1'b0;
            tx_sr_reg    <= '0;
            rx_sr_reg    <= '0;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            slice_reg    <= '0;
            phase_reg    <= 1'b0;
            gap_reg      <= '0;
            sck_reg      <= 1'b0;
            csn_reg      <= 1'b1;
            mosi_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            div_reg      <= div_next;
            cpol_reg     <= cpol_next;
            cpha_reg     <= cpha_next;
            buf_reg      <= buf_next;
            buf_full_reg <= buf_full_next;
            tx_sr_reg    <= tx_sr_next;
            rx_sr_reg    <= rx_sr_next;
            rx_data_reg  <= rx_data_next;
            rx_valid_reg <= rx_valid_next;
            slice_reg    <= slice_next;
            phase_reg    <= phase_next;
            gap_reg      <= gap_next;
            sck_reg      <= sck_next;
            csn_reg      <= csn_next;
            mosi_reg     <= mosi_next;
        end
    end

    assign tx_ready = !buf_full_reg;
    assign rx_valid = rx_valid_reg;
    assign rx_data  = rx_data_reg;
    assign busy     = (state_reg != S_IDLE);
    assign SCK      = sck_reg;
    assign CSn      = csn_reg;
    assign MOSI     = mosi_reg;

endmodule

// File: tb/tb_mspi_master_m.sv
// Directed bench for mspi_master_m: a 32-bit/4-lane instance with a slave model and
// an 8-bit/1-lane instance with MISO tied to MOSI.
module tb_mspi_master_m;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cfg_div;
    logic        cfg_cpol;
    logic        cfg_cpha;

    logic        tx_valid0, tx_ready0, rx_valid0, busy0, SCK0, CSn0;
    logic [31:0] tx_data0, rx_data0;
    logic [3:0]  MOSI0, MISO0;

    logic        tx_valid1, tx_ready1, rx_valid1, busy1, SCK1, CSn1;
    logic [7:0]  tx_data1, rx_data1;
    logic [0:0]  MOSI1, MISO1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mspi_master_m #(.DW(32), .SPI_W(4), .DIV_W(8), .GAP(2)) u0 (
        .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .tx_valid(tx_valid0), .tx_ready(tx_ready0), .tx_data(tx_data0),
        .rx_valid(rx_valid0), .rx_data(rx_data0), .busy(busy0),
        .SCK(SCK0), .CSn(CSn0), .MOSI(MOSI0), .MISO(MISO0)
    );

    mspi_master_m #(.DW(8), .SPI_W(1), .DIV_W(8), .GAP(2)) u1 (
        .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx_data(tx_data1),
        .rx_valid(rx_valid1), .rx_data(rx_data1), .busy(busy1),
        .SCK(SCK1), .CSn(CSn1), .MOSI(MOSI1), .MISO(MISO1)
    );

    assign MISO1 = MOSI1;

    // Slave model for u0: advances one slice after each sampling edge, word taken from slave_q per frame
    logic [31:0] slave_q[$];
    logic [31:0] slave_word = 32'h0;
    logic        s_cpol = 1'b0;
    logic        s_cpha = 1'b0;
    int          sidx = 0;
    logic        s_prev_sck = 1'b0;
    logic        s_prev_csn = 1'b1;

    always @(negedge clk) begin
        if (CSn0) begin
            sidx = 0;
        end else begin
            if (s_prev_csn && slave_q.size() > 0) slave_word = slave_q.pop_front();
            if (SCK0 != s_prev_sck && SCK0 == (s_cpol == s_cpha)) sidx = sidx + 1;
        end
        s_prev_sck = SCK0;
        s_prev_csn = CSn0;
        MISO0 = (sidx < 8) ? slave_word[31 - 4*sidx -: 4] : 4'h0;
    end

    // Frame monitor for u0
    int          frames = 0;
    int          low_cnt = 0, high_cnt = 0;
    int          last_low = 0, last_high = 0, last_rises = 0, rises = 0;
    int          mosi_bad = 0;
    logic        prev_csn = 1'b1, prev_sck = 1'b0;
    logic [3:0]  prev_mosi = 4'h0;
    logic [31:0] rxq[$];

    always @(negedge clk) begin
        if (!CSn0) begin
            if (prev_csn) begin
                last_high = high_cnt;
                low_cnt   = 1;
                rises     = 0;
            end else begin
                low_cnt = low_cnt + 1;
            end
            if (SCK0 && !prev_sck) rises = rises + 1;
            if (MOSI0 != prev_mosi && !(prev_sck && !SCK0)) mosi_bad = mosi_bad + 1;
        end else begin
            if (!prev_csn) begin
                last_low   = low_cnt;
                last_rises = rises;
                frames     = frames + 1;
                high_cnt   = 1;
            end else begin
                high_cnt = high_cnt + 1;
            end
        end
        if (rx_valid0) rxq.push_back(rx_data0);
        prev_csn  = CSn0;
        prev_sck  = SCK0;
        prev_mosi = MOSI0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send0(input logic [31:0] w, output bit ok);
        int n;
        ok = 1'b0;
        @(negedge clk);
        tx_valid0 = 1'b1;
        tx_data0  = w;
        n = 0;
        while (!tx_ready0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (tx_ready0) begin
            ok = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        tx_valid0 = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            #1;
            if (frames >= target) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (!busy0 && tx_ready0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++; if (CSn0 !== 1'b1)     begin bad++; $display("FAIL rst_csn got=%b exp=1", CSn0); end
        total++; if (SCK0 !== 1'b0)     begin bad++; $display("FAIL rst_sck got=%b exp=0", SCK0); end
        total++; if (MOSI0 !== 4'h0)    begin bad++; $display("FAIL rst_mosi got=%h exp=0", MOSI0); end
        total++; if (tx_ready0 !== 1'b1) begin bad++; $display("FAIL rst_tx_ready got=%b exp=1", tx_ready0); end
        total++; if (rx_valid0 !== 1'b0) begin bad++; $display("FAIL rst_rx_valid got=%b exp=0", rx_valid0); end
        total++; if (rx_data0 !== 32'h0) begin bad++; $display("FAIL rst_rx_data got=%h exp=0", rx_data0); end
        total++; if (busy0 !== 1'b0)    begin bad++; $display("FAIL rst_busy got=%b exp=0", busy0); end
        $display("reset: csn=%b sck=%b tx_ready=%b busy=%b", CSn0, SCK0, tx_ready0, busy0);
    endtask

    task automatic test_mode0;
        bit ok;
        int f;
        logic [31:0] w;
        w = 32'hA5C3_0F96;
        cfg_div = 8'd0; cfg_cpol = 1'b0; cfg_cpha = 1'b0;
        s_cpol = 1'b0; s_cpha = 1'b0;
        slave_q.push_back(w);
        rxq.delete();
        #1 f = frames;
        send0(w, ok);
        total++; if (!ok) begin bad++; $display("FAIL m0_accept got=timeout exp=accepted"); end
        wait_frames(f + 1, 500, ok);
        total++; if (!ok) begin bad++; $display("FAIL m0_frame got=timeout exp=frame_end"); end
        total++; if (last_low != 18) begin bad++; $display("FAIL m0_csn_low got=%0d exp=18", last_low); end
        total++; if (last_rises != 8) begin bad++; $display("FAIL m0_sck_rises got=%0d exp=8", last_rises); end
        total++; if (rxq.size() != 1) begin bad++; $display("FAIL m0_rx_count got=%0d exp=1", rxq.size()); end
        total++; if (rx_data0 !== w) begin bad++; $display("FAIL m0_rx_data got=%h exp=%h", rx_data0, w); end
        $display("mode0: tx=%h rx=%h csn_low=%0d rises=%0d", w, rx_data0, last_low, last_rises);
    endtask

    task automatic test_mode3;
        bit ok;
        int f;
        logic [31:0] w, exp_rx;
        w = 32'hCAFE_F00D;
`ifdef MSPI_LOOPBACK_EN
        exp_rx = w;
`else
        exp_rx = 32'h1234_5678;
`endif
        cfg_div = 8'd3; cfg_cpol = 1'b1; cfg_cpha = 1'b1;
        s_cpol = 1'b1; s_cpha = 1'b1;
        slave_q.push_back(32'h1234_5678);
        rxq.delete();
        repeat (2) @(negedge clk);
        total++; if (SCK0 !== 1'b1) begin bad++; $display("FAIL m3_sck_idle got=%b exp=1", SCK0); end
        #1 f = frames;
        mosi_bad = 0;
        send0(w, ok);
        total++; if (!ok) begin bad++; $display("FAIL m3_accept got=timeout exp=accepted"); end
        wait_frames(f + 1, 500, ok);
        total++; if (!ok) begin bad++; $display("FAIL m3_frame got=timeout exp=frame_end"); end
        total++; if (last_low != 72) begin bad++; $display("FAIL m3_csn_low got=%0d exp=72", last_low); end
        total++; if (last_rises != 8) begin bad++; $display("FAIL m3_sck_rises got=%0d exp=8", last_rises); end
        total++; if (mosi_bad != 0) begin bad++; $display("FAIL m3_mosi_edge got=%0d exp=0", mosi_bad); end
        total++; if (rx_data0 !== exp_rx) begin bad++; $display("FAIL m3_rx_data got=%h exp=%h", rx_data0, exp_rx); end
        total++; if (SCK0 !== 1'b1) begin bad++; $display("FAIL m3_sck_after got=%b exp=1", SCK0); end
        $display("mode3: tx=%h rx=%h csn_low=%0d mosi_off_edge=%0d", w, rx_data0, last_low, mosi_bad);
    endtask

    task automatic test_back_to_back;
        bit ok;
        int f;
        cfg_div = 8'd1; cfg_cpol = 1'b0; cfg_cpha = 1'b0;
        s_cpol = 1'b0; s_cpha = 1'b0;
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_idle got=timeout exp=idle"); end
        rxq.delete();
        slave_q.push_back(32'h1111_1111);
        slave_q.push_back(32'h2222_2222);
        #1 f = frames;
        send0(32'h1111_1111, ok);
        send0(32'h2222_2222, ok);
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL b2b_busy_on_write got=%b exp=1", busy0); end
        wait_frames(f + 2, 1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_frames got=timeout exp=2_frames"); end
        total++; if (last_high != 5) begin bad++; $display("FAIL b2b_gap got=%0d exp=5", last_high); end
        total++; if (last_low != 36) begin bad++; $display("FAIL b2b_csn_low got=%0d exp=36", last_low); end
        total++; if (rxq.size() != 2) begin bad++; $display("FAIL b2b_rx_count got=%0d exp=2", rxq.size()); end
        if (rxq.size() == 2) begin
            total++; if (rxq[0] !== 32'h1111_1111) begin bad++; $display("FAIL b2b_rx0 got=%h exp=11111111", rxq[0]); end
            total++; if (rxq[1] !== 32'h2222_2222) begin bad++; $display("FAIL b2b_rx1 got=%h exp=22222222", rxq[1]); end
        end
        $display("back_to_back: gap=%0d rx_count=%0d", last_high, rxq.size());
    endtask

    task automatic test_reset_midframe;
        bit ok;
        int f, n;
        cfg_div = 8'd1; cfg_cpol = 1'b0; cfg_cpha = 1'b0;
        slave_q.delete();
        slave_q.push_back(32'h0F0F_0F0F);
        send0(32'h0F0F_0F0F, ok);
        n = 0;
        while (CSn0 && n < 200) begin @(negedge clk); n++; end
        repeat (8) @(negedge clk);
        send0(32'h3333_3333, ok);
        total++; if (tx_ready0 !== 1'b0) begin bad++; $display("FAIL rm_buf_full got=%b exp=0", tx_ready0); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (CSn0 !== 1'b1)      begin bad++; $display("FAIL rm_csn got=%b exp=1", CSn0); end
        total++; if (SCK0 !== 1'b0)      begin bad++; $display("FAIL rm_sck got=%b exp=0", SCK0); end
        total++; if (tx_ready0 !== 1'b1) begin bad++; $display("FAIL rm_tx_ready got=%b exp=1", tx_ready0); end
        total++; if (busy0 !== 1'b0)     begin bad++; $display("FAIL rm_busy got=%b exp=0", busy0); end
        total++; if (rx_data0 !== 32'h0) begin bad++; $display("FAIL rm_rx_data got=%h exp=0", rx_data0); end
        @(negedge clk);
        rst = 1'b0;
        slave_q.delete();
        rxq.delete();
        #1 f = frames;
        repeat (20) @(negedge clk);
        #1;
        total++; if (frames != f || CSn0 !== 1'b1) begin bad++; $display("FAIL rm_no_restart got=frames+%0d exp=frames+0", frames - f); end
        slave_q.push_back(32'hDEAD_BEEF);
        send0(32'hDEAD_BEEF, ok);
        wait_frames(f + 1, 1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL rm_frame got=timeout exp=frame_end"); end
        total++; if (rxq.size() != 1) begin bad++; $display("FAIL rm_rx_count got=%0d exp=1", rxq.size()); end
        total++; if (rx_data0 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rm_rx_data got=%h exp=deadbeef", rx_data0); end
        $display("reset_midframe: rx=%h", rx_data0);
    endtask

    task automatic test_cfg_change;
        bit ok;
        int f, n;
        cfg_div = 8'd0; cfg_cpol = 1'b0; cfg_cpha = 1'b0;
        s_cpol = 1'b0; s_cpha = 1'b0;
        wait_idle(ok);
        slave_q.push_back(32'h5A5A_5A5A);
        #1 f = frames;
        send0(32'h5A5A_5A5A, ok);
        n = 0;
        while (CSn0 && n < 200) begin @(negedge clk); n++; end
        cfg_div = 8'd7; cfg_cpol = 1'b1;
        wait_frames(f + 1, 500, ok);
        total++; if (last_low != 18) begin bad++; $display("FAIL cc_old_csn_low got=%0d exp=18", last_low); end
        total++; if (last_rises != 8) begin bad++; $display("FAIL cc_old_rises got=%0d exp=8", last_rises); end
        total++; if (rx_data0 !== 32'h5A5A_5A5A) begin bad++; $display("FAIL cc_old_rx got=%h exp=5a5a5a5a", rx_data0); end
        s_cpol = 1'b1;
        wait_idle(ok);
        total++; if (SCK0 !== 1'b1) begin bad++; $display("FAIL cc_new_idle got=%b exp=1", SCK0); end
        slave_q.push_back(32'hC3C3_C3C3);
        #1 f = frames;
        send0(32'hC3C3_C3C3, ok);
        wait_frames(f + 1, 1000, ok);
        total++; if (last_low != 144) begin bad++; $display("FAIL cc_new_csn_low got=%0d exp=144", last_low); end
        total++; if (rx_data0 !== 32'hC3C3_C3C3) begin bad++; $display("FAIL cc_new_rx got=%h exp=c3c3c3c3", rx_data0); end
        $display("cfg_change: old_low=18 new_low=%0d rx=%h", last_low, rx_data0);
    endtask

    task automatic test_narrow;
        int n, low;
        logic psck;
        logic [7:0] exp_bits;
        logic bits[$];
        exp_bits = 8'h81;
        cfg_div = 8'd0; cfg_cpol = 1'b0; cfg_cpha = 1'b0;
        repeat (2) @(negedge clk);
        tx_valid1 = 1'b1;
        tx_data1  = 8'h81;
        @(posedge clk);
        @(negedge clk);
        tx_valid1 = 1'b0;
        n = 0;
        while (CSn1 && n < 100) begin @(negedge clk); n++; end
        psck = SCK1;
        low = 0;
        while (!CSn1 && n < 300) begin
            low++;
            if (SCK1 && !psck) bits.push_back(MOSI1[0]);
            psck = SCK1;
            @(negedge clk);
            n++;
        end
        total++; if (low != 18) begin bad++; $display("FAIL w1_csn_low got=%0d exp=18", low); end
        total++; if (bits.size() != 8) begin bad++; $display("FAIL w1_bit_count got=%0d exp=8", bits.size()); end
        for (int i = 0; i < bits.size() && i < 8; i++) begin
            total++;
            if (bits[i] !== exp_bits[7-i]) begin bad++; $display("FAIL w1_mosi_bit%0d got=%b exp=%b", i, bits[i], exp_bits[7-i]); end
        end
        total++; if (rx_valid1 !== 1'b1) begin bad++; $display("FAIL w1_rx_valid got=%b exp=1", rx_valid1); end
        total++; if (rx_data1 !== 8'h81) begin bad++; $display("FAIL w1_rx_data got=%h exp=81", rx_data1); end
        @(negedge clk);
        total++; if (rx_valid1 !== 1'b0) begin bad++; $display("FAIL w1_rx_valid_pulse got=%b exp=0", rx_valid1); end
        $display("narrow: csn_low=%0d bits=%0d rx=%h", low, bits.size(), rx_data1);
    endtask

    initial begin
        rst = 1'b1;
        cfg_div = 8'd0; cfg_cpol = 1'b0; cfg_cpha = 1'b0;
        tx_valid0 = 1'b0; tx_data0 = 32'h0;
        tx_valid1 = 1'b0; tx_data1 = 8'h0;
        test_reset;
        @(negedge clk);
        rst = 1'b0;
        test_mode0;
        test_mode3;
        test_back_to_back;
        test_reset_midframe;
        test_cfg_change;
        test_narrow;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
